// File: rtl/bus_demux.sv
// Single-outstanding 1:2 request demultiplexer: routes a load/store request to data
// memory (port 0) or MMIO (port 1) by address, steers the completion back, and times out.
module bus_demux #(
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  MMIO_BASE = ADDR_W'(32'h1000_0000),
    parameter int unsigned        TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    // Handshakes: a request moves on a rising edge where valid & ready are both 1.
    // Valid never waits on ready; once raised, valid and its fields stay stable until
    // accepted. Completions (sN_rvalid, rsp_valid) are single-cycle pulses with no ready.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              s0_valid,
    input  logic              s0_ready,
    output logic              s0_we,
    output logic [ADDR_W-1:0] s0_addr,
    output logic [DATA_W-1:0] s0_wdata,
    input  logic              s0_rvalid,
    input  logic [DATA_W-1:0] s0_rdata,
    output logic              s1_valid,
    input  logic              s1_ready,
    output logic              s1_we,
    output logic [ADDR_W-1:0] s1_addr,
    output logic [DATA_W-1:0] s1_wdata,
    input  logic              s1_rvalid,
    input  logic [DATA_W-1:0] s1_rdata,
    output logic              stray_rsp,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // Timer only has to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t            state;
    state_t            state_nxt;
    logic              ready_q;
    logic              sel_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [TW-1:0]     timer_q;
    logic              stray_q;

    logic              sel_ready;
    logic              sel_rvalid;
    logic [DATA_W-1:0] sel_rdata;
    logic              other_rvalid;
    logic              timer_expired;
    logic              stray_set;

    always_comb begin
        sel_ready     = sel_q ? s1_ready  : s0_ready;
        sel_rvalid    = sel_q ? s1_rvalid : s0_rvalid;
        sel_rdata     = sel_q ? s1_rdata  : s0_rdata;
        other_rvalid  = sel_q ? s0_rvalid : s1_rvalid;
        timer_expired = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));
        // Only the selected port may complete, and only while waiting for it.
        stray_set     = (state == WAIT) ? other_rvalid : (s0_rvalid | s1_rvalid);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid && ready_q) state_nxt = SEND;
            SEND:    if (sel_ready) state_nxt = WAIT;
            WAIT:    if (sel_rvalid || timer_expired) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
            stray_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            // Registered ready keeps req_ready free of any path from req_valid.
            ready_q <= (state_nxt == IDLE);
            stray_q <= stray_q | stray_set;
            case (state)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        sel_q   <= (req_addr >= MMIO_BASE);
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                    end
                end
                SEND: begin
                    if (sel_ready) timer_q <= '0;
                end
                WAIT: begin
                    // A completion on the expiry cycle still counts as a success.
                    if (sel_rvalid) begin
                        rdata_q <= we_q ? '0 : sel_rdata;
                        err_q   <= 1'b0;
                    end else if (timer_expired) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid & err_q;

    assign s0_valid  = (state == SEND) && !sel_q;
    assign s0_we     = we_q;
    assign s0_addr   = addr_q;
    assign s0_wdata  = wdata_q;

    assign s1_valid  = (state == SEND) && sel_q;
    assign s1_we     = we_q;
    assign s1_addr   = addr_q;
    assign s1_wdata  = wdata_q;

    assign stray_rsp = stray_q;
    assign state_dbg = state;

endmodule
